// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-read-port register file.
// Imported by the top level and by the read-port slice.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int unsigned RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: zero-index force, clear/reset gating and
// optional byte-merged forwarding of the write presented in the same cycle.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYPASS        = 1
) (
    input  logic                      i_rst,
    input  logic                      i_ready,
    input  logic [ADDRESS_WIDTH-1:0]  i_raddr,
    input  logic [DATA_WIDTH-1:0]     i_stored,
    input  logic [ADDRESS_WIDTH-1:0]  i_addr3,
    input  logic [DATA_WIDTH/8-1:0]   i_we3,
    input  logic [DATA_WIDTH-1:0]     i_wd3,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(RF_ZERO_IDX);

    logic w_zero_read;
    logic w_hit;

    assign w_zero_read = i_rst || !i_ready || (i_raddr == ZERO_IDX);
    assign w_hit       = i_ready && (|i_we3) && (i_addr3 != ZERO_IDX) && (i_raddr == i_addr3);

    always_comb begin
        o_rdata = i_stored;
        // Write-first: enabled bytes come from the incoming data, others from storage.
        if ((BYPASS != 0) && w_hit) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (i_we3[b]) begin
                    o_rdata[8*b +: 8] = i_wd3[8*b +: 8];
                end
            end
        end
        if (w_zero_read) begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes, optional bypass,
// a sequential post-reset clear engine and a registered debug tap.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_READ      = 2,
    parameter int unsigned BYPASS        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rdata,
    input  logic [ADDRESS_WIDTH-1:0]          addr3,
    input  logic [DATA_WIDTH/8-1:0]           we3,
    input  logic [DATA_WIDTH-1:0]             wd3,
    output logic                              ready,
    input  logic [ADDRESS_WIDTH-1:0]          dbg_addr,
    output logic [DATA_WIDTH-1:0]             dbg_data
);

    localparam int unsigned DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(RF_ZERO_IDX);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE_IDX  = ADDRESS_WIDTH'(1);

    rf_state_t               r_state;
    logic [ADDRESS_WIDTH-1:0] r_cnt;
    logic                     r_ready;
    logic [DATA_WIDTH-1:0]    r_dbg_data;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

    // Clear engine walks 1..DEPTH-1 once per reset; index 0 is never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RF_CLEAR;
            r_cnt      <= ONE_IDX;
            r_ready    <= 1'b0;
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= (dbg_addr == ZERO_IDX) ? '0 : r_mem[dbg_addr];
            case (r_state)
                RF_CLEAR: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= RF_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE_IDX;
                    end
                end
                RF_READY: begin
                    r_state <= RF_READY;
                end
                default: begin
                    r_state <= RF_CLEAR;
                end
            endcase
        end
    end

    // Single write port shared by the clear engine and the datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == RF_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (addr3 != ZERO_IDX) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (we3[b]) begin
                        r_mem[addr3][8*b +: 8] <= wd3[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ready    = r_ready;
    assign dbg_data = r_dbg_data;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rport
        logic [ADDRESS_WIDTH-1:0] w_raddr;
        logic [DATA_WIDTH-1:0]    w_stored;
        logic [DATA_WIDTH-1:0]    w_rdata;

        assign w_raddr  = raddr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_stored = r_mem[w_raddr];
        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rdata;

        regfile_rport #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH),
            .BYPASS        (BYPASS)
        ) u_rport (
            .i_rst    (rst),
            .i_ready  (r_ready),
            .i_raddr  (w_raddr),
            .i_stored (w_stored),
            .i_addr3  (addr3),
            .i_we3    (we3),
            .i_wd3    (wd3),
            .o_rdata  (w_rdata)
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a 4-port bypassing instance and a 2-port read-old
// instance share write/debug stimulus and are checked against an array model.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  raddr;
    logic [127:0] rdata4;
    logic [63:0]  rdata2;
    logic [4:0]   addr3;
    logic [3:0]   we3;
    logic [31:0]  wd3;
    logic         ready4;
    logic         ready2;
    logic [4:0]   dbg_addr;
    logic [31:0]  dbg4;
    logic [31:0]  dbg2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [32];
    bit          m_ready;
    int          m_cleared;
    logic [31:0] m_dbg;

    always #5 clk = ~clk;

    regfile_mp #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .NUM_READ      (4),
        .BYPASS        (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .rdata    (rdata4),
        .addr3    (addr3),
        .we3      (we3),
        .wd3      (wd3),
        .ready    (ready4),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg4)
    );

    regfile_mp #(
        .ADDRESS_WIDTH (5),
        .DATA_WIDTH    (32),
        .NUM_READ      (2),
        .BYPASS        (0)
    ) dut_nb (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr[9:0]),
        .rdata    (rdata2),
        .addr3    (addr3),
        .we3      (we3),
        .wd3      (wd3),
        .ready    (ready2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg2)
    );

    // Reference behaviour of one rising edge, from the inputs held at that edge.
    task automatic model_edge();
        logic [31:0] dbg_src;
        dbg_src = (dbg_addr == 5'd0) ? 32'd0 : m_mem[dbg_addr];
        if (rst) begin
            m_ready   = 1'b0;
            m_cleared = 0;
            m_dbg     = 32'd0;
        end else begin
            m_dbg = dbg_src;
            if (!m_ready) begin
                m_cleared++;
                m_mem[m_cleared] = 32'd0;
                if (m_cleared == 31) m_ready = 1'b1;
            end else if (addr3 != 5'd0) begin
                for (int b = 0; b < 4; b++) begin
                    if (we3[b]) m_mem[addr3][8*b +: 8] = wd3[8*b +: 8];
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (rst || !m_ready || a == 5'd0) return 32'd0;
        v = m_mem[a];
        if (byp && we3 != 4'd0 && addr3 == a) begin
            for (int b = 0; b < 4; b++) begin
                if (we3[b]) v[8*b +: 8] = wd3[8*b +: 8];
            end
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        addr3 = 5'd0;
        we3   = 4'd0;
        wd3   = 32'd0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] we, input logic [31:0] d);
        addr3 = a;
        we3   = we;
        wd3   = d;
        tick();
        set_idle();
    endtask

    task automatic set_all_raddr(input logic [4:0] a);
        raddr = {a, a, a, a};
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(ready4 === 1'b1 && ready2 === 1'b1) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!(ready4 === 1'b1 && ready2 === 1'b1)) begin
            failures++;
            $display("FAIL wait_ready: ready4=%b ready2=%b, required 1 within 40 cycles",
                     ready4, ready2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        set_all_raddr(5'd5);
        dbg_addr = 5'd5;
        tick();
        tick();
        checks++;
        if (ready4 !== 1'b0 || ready2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b, required 0", ready4, ready2);
        end
        checks++;
        if (rdata4 !== 128'd0 || rdata2 !== 64'd0) begin
            failures++;
            $display("FAIL reset_rdata: got %h/%h, required 0", rdata4, rdata2);
        end
        checks++;
        if (dbg4 !== 32'd0 || dbg2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_dbg: got %h/%h, required 0", dbg4, dbg2);
        end
        rst = 1'b0;
        wait_ready();
        do_write(5'd5, 4'hF, 32'hDEADBEEF);
        #1;
        checks++;
        if (rdata4[31:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL preload_r5: got %h, required deadbeef", rdata4[31:0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            checks++;
            if (ready4 !== (i == 31) || ready2 !== (i == 31)) begin
                failures++;
                $display("FAIL clear_timing: edge %0d ready=%b/%b, required %b",
                         i, ready4, ready2, (i == 31));
            end
        end
        checks++;
        if (rdata4[31:0] !== 32'd0 || rdata2[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL clear_r5: got %h/%h, required 0", rdata4[31:0], rdata2[31:0]);
        end
    endtask

    task automatic test_byte_enables();
        do_write(5'd7, 4'hF, 32'h11223344);
        do_write(5'd7, 4'b0101, 32'hAABBCCDD);
        set_all_raddr(5'd7);
        #1;
        checks++;
        if (rdata4[31:0] !== 32'h11BB33DD || rdata2[63:32] !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL byte_enable: got %h/%h, required 11bb33dd",
                     rdata4[31:0], rdata2[63:32]);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd3, 4'hF, 32'hA5A5A5A5);
        set_all_raddr(5'd3);
        addr3 = 5'd3;
        we3   = 4'hF;
        wd3   = 32'h12345678;
        #1;
        checks++;
        if (rdata4[31:0] !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_on: got %h, required 12345678", rdata4[31:0]);
        end
        checks++;
        if (rdata2[31:0] !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass_off_old: got %h, required a5a5a5a5", rdata2[31:0]);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (rdata2[31:0] !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_off_new: got %h, required 12345678", rdata2[31:0]);
        end
    endtask

    task automatic test_x0();
        set_all_raddr(5'd0);
        addr3 = 5'd0;
        we3   = 4'hF;
        wd3   = 32'hFFFFFFFF;
        #1;
        checks++;
        if (rdata4 !== 128'd0 || rdata2 !== 64'd0) begin
            failures++;
            $display("FAIL x0_same_cycle: got %h/%h, required 0", rdata4, rdata2);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (rdata4 !== 128'd0 || rdata2 !== 64'd0) begin
            failures++;
            $display("FAIL x0_after: got %h/%h, required 0", rdata4, rdata2);
        end
    endtask

    task automatic test_write_during_clear();
        do_write(5'd9, 4'hF, 32'h99999999);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        set_all_raddr(5'd9);
        addr3 = 5'd9;
        we3   = 4'hF;
        wd3   = 32'h0BADF00D;
        #1;
        checks++;
        if (rdata4[31:0] !== 32'd0 || ready4 !== 1'b0) begin
            failures++;
            $display("FAIL clear_gating: rdata=%h ready=%b, required 0/0", rdata4[31:0], ready4);
        end
        tick();
        set_idle();
        wait_ready();
        checks++;
        if (rdata4[31:0] !== 32'd0 || rdata2[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL write_in_clear: r9=%h/%h, required 0", rdata4[31:0], rdata2[31:0]);
        end
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            checks++;
            if (ready4 !== (i == 31) || ready2 !== (i == 31)) begin
                failures++;
                $display("FAIL mid_clear_timing: edge %0d ready=%b/%b, required %b",
                         i, ready4, ready2, (i == 31));
            end
        end
    endtask

    task automatic test_multiport_dbg();
        do_write(5'd10, 4'hF, 32'hCAFEF00D);
        set_all_raddr(5'd10);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdata4[k*32 +: 32] !== 32'hCAFEF00D) begin
                failures++;
                $display("FAIL multiport: port %0d got %h, required cafef00d",
                         k, rdata4[k*32 +: 32]);
            end
        end
        dbg_addr = 5'd10;
        tick();
        checks++;
        if (dbg4 !== 32'hCAFEF00D || dbg2 !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL dbg_tap: got %h/%h, required cafef00d", dbg4, dbg2);
        end
        addr3 = 5'd10;
        we3   = 4'hF;
        wd3   = 32'h01020304;
        tick();
        set_idle();
        checks++;
        if (dbg4 !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL dbg_old_on_write: got %h, required cafef00d", dbg4);
        end
        tick();
        checks++;
        if (dbg4 !== 32'h01020304 || dbg2 !== 32'h01020304) begin
            failures++;
            $display("FAIL dbg_new: got %h/%h, required 01020304", dbg4, dbg2);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 149) == 0);
            addr3    = 5'($urandom_range(0, 7));
            we3      = 4'($urandom);
            wd3      = $urandom;
            dbg_addr = 5'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++) begin
                raddr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? addr3 : 5'($urandom_range(0, 7));
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                e = exp_read(raddr[k*5 +: 5], 1'b1);
                checks++;
                if (rdata4[k*32 +: 32] !== e) begin
                    failures++;
                    $display("FAIL rand_read4: iter %0d port %0d got %h, required %h",
                             n, k, rdata4[k*32 +: 32], e);
                end
            end
            for (int k = 0; k < 2; k++) begin
                e = exp_read(raddr[k*5 +: 5], 1'b0);
                checks++;
                if (rdata2[k*32 +: 32] !== e) begin
                    failures++;
                    $display("FAIL rand_read2: iter %0d port %0d got %h, required %h",
                             n, k, rdata2[k*32 +: 32], e);
                end
            end
            checks++;
            if (dbg4 !== m_dbg || dbg2 !== m_dbg || ready4 !== m_ready) begin
                failures++;
                $display("FAIL rand_dbg_ready: iter %0d dbg=%h/%h ready=%b, required %h/%b",
                         n, dbg4, dbg2, ready4, m_dbg, m_ready);
            end
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_ready   = 1'b0;
        m_cleared = 0;
        m_dbg     = 32'd0;
        raddr     = '0;
        dbg_addr  = 5'd0;
        test_reset();
        test_byte_enables();
        test_bypass();
        test_x0();
        test_write_during_clear();
        test_reset_mid_clear();
        test_multiport_dbg();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the RV32 datapath: the next generation of the single-cycle core's 2R1W register file. It adds a configurable read-port count, byte-enabled writes, optional write-to-read bypass, a sequential post-reset clear engine, and a registered debug tap in place of the fixed a0 output. Register 0 reads as zero on every port. It sits between decode, which supplies the addresses, and the ALU/writeback path.

## Interface
- `ADDRESS_WIDTH`, 5: register index width; DEPTH = 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, 32: register width; must be a multiple of 8.
- `NUM_READ`, 2: number of combinational read ports, 1..4.
- `BYPASS`, 1: 1 = write-first forwarding to reads in the write cycle; 0 = read-old.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `raddr` input NUM_READ*ADDRESS_WIDTH: read addresses; port k uses bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- `rdata` output NUM_READ*DATA_WIDTH: read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- `addr3` input ADDRESS_WIDTH: write address (rd).
- `we3` input DATA_WIDTH/8: per-byte write enables.
- `wd3` input DATA_WIDTH: write data.
- `ready` output 1: high when the clear engine is idle and writes are accepted.
- `dbg_addr` input ADDRESS_WIDTH: debug tap index.
- `dbg_data` output DATA_WIDTH: registered contents of the register at dbg_addr.

## Operation
- FSM states are CLEAR and READY.
  - Any edge with rst=1: state<=CLEAR, cnt<=1, dbg_data<=0. This overrides everything, including a clear already in progress.
  - In CLEAR with rst=0: array[cnt]<=0. If cnt==DEPTH-1, state<=READY; otherwise cnt<=cnt+1.
  - In READY: the FSM stays in READY until rst.
- `ready` = (state==READY). Reset value is 0.
- Writes:
  - A write is performed only in READY, with addr3!=0 and we3[b]=1. Byte b of array[addr3] takes wd3[8b+7:8b]; bytes with we3[b]=0 are unchanged.
  - Writes presented during CLEAR or during rst are dropped, not queued.
- Reads are combinational on every port. rdata_k is 0 in each of these cases:
  - raddr_k==0;
  - state==CLEAR;
  - rst==1.
- Otherwise rdata_k = array[raddr_k], with one exception. If BYPASS=1, ready=1, |we3, addr3!=0 and raddr_k==addr3, then rdata_k takes wd3 on enabled bytes and the stored value on the other bytes.
- Debug tap: each edge with rst=0 loads dbg_data<=array[dbg_addr], where index 0 gives 0 and there is no bypass. Reset value is 0.
- Multiple read ports may share an address; each returns identical data.

## Timing
- Read latency is 0 cycles (combinational). Write takes effect at the next rising edge. Debug tap latency is 1 cycle.
- Clear duration is DEPTH-1 cycles after the first edge with rst=0. With DEPTH=32, `ready` rises 31 edges after rst deasserts.
- When a write and a dbg read hit the same address on one edge, dbg_data captures the old value.
- Register 0 is never written. It is not part of the clear sequence; the cnt range is 1..DEPTH-1.
- cnt is ADDRESS_WIDTH bits wide and does not wrap: the transition to READY occurs at DEPTH-1.

## Structure
- `regfile_pkg` holds the state enum `rf_state_t` {RF_CLEAR, RF_READY} and the constant `RF_ZERO_IDX = 0`.
- One sub-module, `regfile_rport`: a single combinational read port (zero-index force, clear gating, bypass byte merge), instantiated NUM_READ times in a generate loop.
- The storage array is a single memory with one write port, suitable for distributed RAM.

## Test plan
- Reset/clear: preload r5=0xDEADBEEF, pulse rst for one cycle.
  - `ready` stays 0 for 31 cycles, then reads 1.
  - Reading r5 after that returns 0x00000000.
- Byte enables: write r7=0x11223344 with we3=4'hF, then wd3=0xAABBCCDD with we3=4'b0101.
  - Reading r7 returns 0x11BB33DD.
- Bypass: with BYPASS=1, write r3=0x12345678 while raddr port0=3.
  - rdata0=0x12345678 in the same cycle.
  - With BYPASS=0, the same stimulus gives the old value until the next cycle.
- x0 and write during clear:
  - Write r0=0xFFFFFFFF: every port reading 0 gets 0.
  - A write to r9 issued at clear cycle 10 is lost: r9=0 once ready.
- Reset mid-clear: assert rst at clear cycle 15.
  - cnt restarts and `ready` rises 31 cycles after the second release, not earlier.
- Debug tap and multi-port: NUM_READ=4, all ports at r10=0xCAFEF00D.
  - All four return the value.
  - dbg_addr=10 gives dbg_data=0xCAFEF00D one edge later.
  - A simultaneous write to r10 is visible on dbg_data only one edge after that.
